// File: rtl/pe42_pkg.sv
// pe42_pkg: shared types and constants for the pe42_d priority encoder.
//   CODE_W          width of the encoded index
//   code_t          encoded index type
//   CODE_Y0..Y3     index codes for each request line
//   IDLE_CODE       default code when no request line is asserted
package pe42_pkg;

   localparam int CODE_W = 2;

   typedef logic [CODE_W-1:0] code_t;

   localparam code_t CODE_Y0   = 2'b00;
   localparam code_t CODE_Y1   = 2'b01;
   localparam code_t CODE_Y2   = 2'b10;
   localparam code_t CODE_Y3   = 2'b11;
   localparam code_t IDLE_CODE = 2'b00;

endpackage

// File: rtl/pe42_d_if.sv
// pe42_d_if: request/encoded-result bundle for pe42_d.
//   Y0..Y3  request lines (Y3 highest priority)
//   A0, A1  encoded index
//   V       valid, at least one request asserted
//   P       parity of the requests (only with PE42_D_PARITY_EN)
// master: drives requests, observes result. slave: the encoder.
interface pe42_d_if;
   logic Y0;
   logic Y1;
   logic Y2;
   logic Y3;
   logic A0;
   logic A1;
   logic V;
`ifdef PE42_D_PARITY_EN
   logic P;
`endif

   modport master (
      output Y0, Y1, Y2, Y3,
`ifdef PE42_D_PARITY_EN
      input  P,
`endif
      input  A0, A1, V
   );

   modport slave (
      input  Y0, Y1, Y2, Y3,
`ifdef PE42_D_PARITY_EN
      output P,
`endif
      output A0, A1, V
   );
endinterface

// File: rtl/pe42_enc_comb.sv
// pe42_enc_comb: combinational 4-to-2 priority encoder, highest index wins.
//   i_y       request lines [3:0]
//   o_code    encoded index, IDLE_CODE when no request is set
//   o_valid   OR of all requests
//   o_parity  XOR of all requests (only with PE42_D_PARITY_EN)
import pe42_pkg::*;

module pe42_enc_comb #(
   parameter code_t IDLE_CODE = pe42_pkg::IDLE_CODE
) (
   input  logic [3:0] i_y,
`ifdef PE42_D_PARITY_EN
   output logic       o_parity,
`endif
   output code_t      o_code,
   output logic       o_valid
);

   always_comb begin
      o_code = IDLE_CODE;
      if (i_y[3])      o_code = CODE_Y3;
      else if (i_y[2]) o_code = CODE_Y2;
      else if (i_y[1]) o_code = CODE_Y1;
      else if (i_y[0]) o_code = CODE_Y0;
   end

   assign o_valid = |i_y;

`ifdef PE42_D_PARITY_EN
   assign o_parity = ^i_y;
`endif

endmodule

// File: rtl/pe42_d.sv
// pe42_d: 4-to-2 priority encoder with optional output register.
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset (clears registered outputs)
//   bus   pe42_d_if.slave: Y0..Y3 in, A1:A0 / V (/ P) out
// Parameters:
//   REG_OUT   1 = outputs registered (1-cycle latency), 0 = combinational
//   IDLE_CODE code driven on A1:A0 when no request is asserted
// Macro PE42_D_PARITY_EN adds output P = Y3^Y2^Y1^Y0 with the same timing.
import pe42_pkg::*;

module pe42_d #(
   parameter bit    REG_OUT   = 1'b1,
   parameter code_t IDLE_CODE = pe42_pkg::IDLE_CODE
) (
   input  logic    clk,
   input  logic    rst,
   pe42_d_if.slave bus
);

   code_t w_code;
   logic  w_valid;
`ifdef PE42_D_PARITY_EN
   logic  w_parity;
`endif

   pe42_enc_comb #(
      .IDLE_CODE (IDLE_CODE)
   ) u_enc (
      .i_y      ({bus.Y3, bus.Y2, bus.Y1, bus.Y0}),
`ifdef PE42_D_PARITY_EN
      .o_parity (w_parity),
`endif
      .o_code   (w_code),
      .o_valid  (w_valid)
   );

   generate
      if (REG_OUT) begin : g_reg
         code_t r_code;
         logic  r_valid;
`ifdef PE42_D_PARITY_EN
         logic  r_parity;
`endif

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_code   <= IDLE_CODE;
               r_valid  <= 1'b0;
`ifdef PE42_D_PARITY_EN
               r_parity <= 1'b0;
`endif
            end else begin
               r_code   <= w_code;
               r_valid  <= w_valid;
`ifdef PE42_D_PARITY_EN
               r_parity <= w_parity;
`endif
            end
         end

         assign bus.A1 = r_code[1];
         assign bus.A0 = r_code[0];
         assign bus.V  = r_valid;
`ifdef PE42_D_PARITY_EN
         assign bus.P  = r_parity;
`endif
      end else begin : g_comb
         // Pass-through: clk and rst intentionally have no effect here.
         assign bus.A1 = w_code[1];
         assign bus.A0 = w_code[0];
         assign bus.V  = w_valid;
`ifdef PE42_D_PARITY_EN
         assign bus.P  = w_parity;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_pe42_d.sv
// tb_pe42_d: self-checking bench for pe42_d (REG_OUT=1, IDLE_CODE=00).
// Expected results are queued when a request pattern is driven and
// compared one edge later. Builds with or without PE42_D_PARITY_EN.
`timescale 1ns/1ps
module tb_pe42_d;

   typedef struct packed {
      logic [1:0] a;
      logic       v;
      logic       p;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   exp_t exp_q[$];

   pe42_d_if u_if ();

   pe42_d #(
      .REG_OUT   (1'b1),
      .IDLE_CODE (2'b00)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: scan from the highest line down.
   function automatic exp_t model(input logic [3:0] y);
      exp_t e;
      e.a = 2'b00;
      e.v = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (y[i] && !e.v) begin
            e.a = 2'(i);
            e.v = 1'b1;
         end
      end
      e.p = y[0] ^ y[1] ^ y[2] ^ y[3];
      return e;
   endfunction

   function automatic logic [3:0] observed();
`ifdef PE42_D_PARITY_EN
      return {u_if.A1, u_if.A0, u_if.V, u_if.P};
`else
      return {u_if.A1, u_if.A0, u_if.V, 1'b0};
`endif
   endfunction

   function automatic logic [3:0] to_vec(input exp_t e);
`ifdef PE42_D_PARITY_EN
      return {e.a, e.v, e.p};
`else
      return {e.a, e.v, 1'b0};
`endif
   endfunction

   task automatic drive(input logic [3:0] y);
      {u_if.Y3, u_if.Y2, u_if.Y1, u_if.Y0} = y;
      exp_q.push_back(model(y));
   endtask

   // Wait for the sampling edge, then compare against the oldest queued result.
   task automatic check_next(input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk({tag, "_queue_empty"}, 4'd1, 4'd0);
      end else begin
         e = exp_q.pop_front();
         chk(tag, observed(), to_vec(e));
      end
   endtask

   task automatic hold_and_check(input string tag, input logic [3:0] y, input int cycles);
      exp_t e;
      drive(y);
      check_next(tag);
      e = model(y);
      repeat (cycles - 1) @(posedge clk);
      #1;
      chk({tag, "_held"}, observed(), to_vec(e));
   endtask

   initial begin
      logic [3:0] y_rand;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      {u_if.Y3, u_if.Y2, u_if.Y1, u_if.Y0} = 4'b0000;
      #1;
      chk("reset_state", observed(), 4'b0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset asserted mid-cycle with Y3 held: outputs clear without an edge.
      @(posedge clk); #1;
      drive(4'b1000);
      check_next("pre_reset_y3");
      @(negedge clk);
      chk("pre_reset_hold", observed(), to_vec(model(4'b1000)));
      rst = 1'b1;
      #1;
      chk("async_reset", observed(), 4'b0000);
      @(posedge clk); #1;
      chk("reset_hold", observed(), 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(model(4'b1000));
      check_next("post_reset_y3");

      // One-hot sweep and idle, 100 ns each.
      hold_and_check("onehot_y0", 4'b0001, 10);
      hold_and_check("onehot_y1", 4'b0010, 10);
      hold_and_check("onehot_y2", 4'b0100, 10);
      hold_and_check("onehot_y3", 4'b1000, 10);
      hold_and_check("all_zero",  4'b0000, 10);

      // Multi-hot priority and parity patterns.
      hold_and_check("prio_1111", 4'b1111, 2);
      hold_and_check("prio_0101", 4'b0101, 2);
      hold_and_check("prio_0011", 4'b0011, 2);
      hold_and_check("prio_1001", 4'b1001, 2);
      hold_and_check("par_0111",  4'b0111, 2);
      hold_and_check("par_0000",  4'b0000, 2);

      // Latency: change just after an edge, outputs wait for the next edge.
      hold_and_check("lat_0001", 4'b0001, 1);
      drive(4'b1000);
      @(negedge clk);
      chk("lat_before_edge", observed(), to_vec(model(4'b0001)));
      check_next("lat_after_edge");

      // Glitch between edges is invisible.
      @(negedge clk);
      {u_if.Y3, u_if.Y2, u_if.Y1, u_if.Y0} = 4'b0000;
      #2;
      {u_if.Y3, u_if.Y2, u_if.Y1, u_if.Y0} = 4'b0010;
      exp_q.push_back(model(4'b0010));
      check_next("glitch_ignored");

      // Back-to-back random patterns, one per cycle.
      for (int i = 0; i < 16; i++) begin
         y_rand = 4'($urandom_range(0, 15));
         drive(y_rand);
         check_next("random");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
